// File: rtl/decryption.sv
// Fully pipelined keyed block decryptor: one ciphertext word per clock, plaintext ROUNDS cycles later.
// Optional macro DECRYPTION_VALID_EN adds an in_valid/out_valid sideband pipelined with each word.
module decryption #(
    parameter int N      = 8,
    parameter int ROUNDS = 4
) (
    input  logic         clock,
    input  logic [N-1:0] key,
    input  logic [N-1:0] e_data,
    output logic [N-1:0] data,
    input  logic         reset
`ifdef DECRYPTION_VALID_EN
    ,
    input  logic         in_valid,
    output logic         out_valid
`endif
);

    // Round key: key rotated left by (r mod N), XORed with the zero-extended round number plus one.
    function automatic logic [N-1:0] round_key(input logic [N-1:0] k, input int r);
        int sh;
        sh = r % N;
        return ((k << sh) | (k >> (N - sh))) ^ N'(r + 1);
    endfunction

    // Inverse of y = rotl(x ^ rk, 1) + rk.
    function automatic logic [N-1:0] dec_round(input logic [N-1:0] y, input logic [N-1:0] k,
                                               input int r);
        logic [N-1:0] rk;
        logic [N-1:0] d;
        rk = round_key(k, r);
        d  = y - rk;
        return {d[0], d[N-1:1]} ^ rk;
    endfunction

    logic [N-1:0] data_reg   [ROUNDS];
    logic [N-1:0] key_reg    [ROUNDS];
    logic [N-1:0] round_next [ROUNDS];

    // Stage gi+1 undoes round ROUNDS-1-gi, so the highest round is peeled off first.
    generate
        for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign round_next[gi] = dec_round(e_data, key, ROUNDS - 1);
            end else begin : g_later
                assign round_next[gi] = dec_round(data_reg[gi-1], key_reg[gi-1], ROUNDS - 1 - gi);
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ROUNDS; i++) begin
                data_reg[i] <= '0;
                key_reg[i]  <= '0;
            end
        end else begin
            key_reg[0] <= key;
            for (int i = 0; i < ROUNDS; i++) begin
                data_reg[i] <= round_next[i];
            end
            for (int i = 1; i < ROUNDS; i++) begin
                key_reg[i] <= key_reg[i-1];
            end
        end
    end

    assign data = data_reg[ROUNDS-1];

`ifdef DECRYPTION_VALID_EN
    logic [ROUNDS-1:0] valid_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg[0] <= in_valid;
            for (int i = 1; i < ROUNDS; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[ROUNDS-1];
`endif

endmodule

// File: tb/tb_decryption.sv
// Self-checking bench for decryption: table vectors, reset-in-flight sequence and a random
// encrypt/decrypt round trip scored against a high-level cipher model.
module tb_decryption;

    localparam int N      = 8;
    localparam int ROUNDS = 4;

    logic         clock;
    logic         reset;
    logic [N-1:0] key;
    logic [N-1:0] e_data;
    logic [N-1:0] data;
`ifdef DECRYPTION_VALID_EN
    logic         in_valid;
    logic         out_valid;
`endif

    decryption #(.N(N), .ROUNDS(ROUNDS)) dut (
        .clock    (clock),
        .key      (key),
        .e_data   (e_data),
        .data     (data),
        .reset    (reset)
`ifdef DECRYPTION_VALID_EN
        ,
        .in_valid (in_valid),
        .out_valid(out_valid)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] k;
        logic [7:0] e;
        logic [7:0] exp;
        logic       v;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        logic       v;
    } pend_t;

    int    assertions = 0;
    int    failures   = 0;
    string phase      = "init";
    pend_t pend[$];

    // Cipher model, plain integer arithmetic on 8-bit values.
    function automatic int m_rk(input int k, input int r);
        int s;
        s = r % N;
        return (((k << s) | (k >> (N - s))) & 255) ^ (r + 1);
    endfunction

    function automatic logic [7:0] m_encrypt(input logic [7:0] p, input logic [7:0] k);
        int x, t, rk;
        x = p;
        for (int r = 0; r < ROUNDS; r++) begin
            rk = m_rk(k, r);
            t  = x ^ rk;
            t  = ((t << 1) | (t >> 7)) & 255;
            x  = (t + rk) & 255;
        end
        return x[7:0];
    endfunction

    function automatic logic [7:0] m_decrypt(input logic [7:0] c, input logic [7:0] k);
        int y, t, rk;
        y = c;
        for (int r = ROUNDS - 1; r >= 0; r--) begin
            rk = m_rk(k, r);
            t  = (y - rk) & 255;
            t  = ((t >> 1) | (t << 7)) & 255;
            y  = t ^ rk;
        end
        return y[7:0];
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: data=%h expected=%h at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: value=%b expected=%b at %0t", phase, name, act, exp, $time);
        end
    endtask

    // One clock: drive, let the edge sample, then score the output against the delay queue.
    task automatic step(input logic [7:0] k, input logic [7:0] e, input logic [7:0] exp,
                        input logic v, input logic rst);
        pend_t p;
        reset  = rst;
        key    = k;
        e_data = e;
`ifdef DECRYPTION_VALID_EN
        in_valid = v;
`endif
        @(posedge clock);
        #1;
        if (rst) begin
            pend.delete();
            check8("reset_data", data, 8'h00);
`ifdef DECRYPTION_VALID_EN
            check1("reset_valid", out_valid, 1'b0);
`endif
        end else begin
            p.exp = exp;
            p.v   = v;
            pend.push_back(p);
            if (pend.size() > ROUNDS) void'(pend.pop_front());
            if (pend.size() == ROUNDS) begin
                check8("data", data, pend[0].exp);
`ifdef DECRYPTION_VALID_EN
                check1("out_valid", out_valid, pend[0].v);
`endif
            end else begin
`ifdef DECRYPTION_VALID_EN
                check1("fill_valid", out_valid, 1'b0);
`endif
            end
        end
        $display("cyc rst=%b key=%h e_data=%h -> data=%h", rst, k, e, data);
    endtask

    vec_t       tbl[8];
    logic [7:0] banned[3];
    logic [7:0] pk, kk;

    initial begin
        reset = 1'b1; key = '0; e_data = '0;
`ifdef DECRYPTION_VALID_EN
        in_valid = 1'b0;
`endif
        // Hand-derived vectors first, then back-to-back key changes scored by the model.
        tbl[0] = '{k: 8'h00, e: 8'h01, exp: 8'h3D, v: 1'b1};
        tbl[1] = '{k: 8'hFF, e: 8'h00, exp: 8'h4E, v: 1'b0};
        tbl[2] = '{k: 8'h01, e: 8'h00, exp: 8'h00, v: 1'b1};
        tbl[3] = '{k: 8'h79, e: 8'h0F, exp: 8'h00, v: 1'b1};
        tbl[4] = '{k: 8'h80, e: 8'hA0, exp: 8'h00, v: 1'b0};
        tbl[5] = '{k: 8'h00, e: 8'hFF, exp: 8'h00, v: 1'b1};
        tbl[6] = '{k: 8'h5A, e: 8'hC3, exp: 8'h00, v: 1'b0};
        tbl[7] = '{k: 8'h00, e: 8'h01, exp: 8'h3D, v: 1'b1};
        for (int i = 2; i < 7; i++) tbl[i].exp = m_decrypt(tbl[i].e, tbl[i].k);

        phase = "reset";
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        phase = "table";
        for (int i = 0; i < 8; i++) step(tbl[i].k, tbl[i].e, tbl[i].exp, tbl[i].v, 1'b0);

        phase = "roundtrip";
        for (int i = 0; i < 500; i++) begin
            pk = 8'($urandom_range(0, 255));
            kk = 8'($urandom_range(0, 255));
            step(kk, m_encrypt(pk, kk), pk, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Three words in flight, then a one-cycle reset must discard them.
        phase = "reset_inflight";
        banned[0] = 8'h11; banned[1] = 8'h22; banned[2] = 8'h33;
        for (int i = 0; i < 3; i++) step(8'h3C, m_encrypt(banned[i], 8'h3C), banned[i], 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(8'hC5, m_encrypt(8'h44 + 8'(i), 8'hC5), 8'h44 + 8'(i), 1'b1, 1'b0);
            for (int j = 0; j < 3; j++) begin
                assertions++;
                if (data === banned[j]) begin
                    failures++;
                    $display("FAIL %s/discard: data=%h equals in-flight word %h", phase, data, banned[j]);
                end
            end
        end
        step(8'h12, m_encrypt(8'h47, 8'h12), 8'h47, 1'b1, 1'b0);

        phase = "flush";
        for (int i = 0; i < ROUNDS; i++) begin
            kk = 8'($urandom_range(0, 255));
            pk = 8'($urandom_range(0, 255));
            step(kk, pk, m_decrypt(pk, kk), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
